// File: rtl/cmos_dvp_tx.sv
// OV7670-style DVP transmitter: emits synthetic RGB565 frames (high byte first)
// on pclk/href/vsync/db, with pclk = clk/2 and outputs changing on pclk falls.
module cmos_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [15:0] solid_rgb,
    output logic        cmos_pclk,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_db,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int          LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int          BAR_W      = H_ACTIVE / 8;
    localparam logic [10:0] H_LAST     = 11'(LINE_BYTES - 1);
    localparam logic [10:0] HREF_END   = 11'(2 * H_ACTIVE);

    // FEND is the byte period following the last VFRONT byte; it closes the frame.
    typedef enum logic [2:0] {
        IDLE, VSYNC, VBACK, ACTIVE, VFRONT, FEND
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        pclk_q, pclk_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  db_q, db_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  pat_q;
    logic [15:0] solid_q;
    logic        latch;
    logic [15:0] pix;

    function automatic logic [9:0] last_line(input state_t s);
        logic [9:0] n;
        case (s)
            VSYNC:   n = 10'(VSYNC_LINES - 1);
            VBACK:   n = 10'(V_BACK - 1);
            ACTIVE:  n = 10'(V_ACTIVE - 1);
            VFRONT:  n = 10'(V_FRONT - 1);
            default: n = 10'd0;
        endcase
        return n;
    endfunction

    function automatic state_t next_state(input state_t s);
        state_t n;
        case (s)
            VSYNC:   n = VBACK;
            VBACK:   n = ACTIVE;
            ACTIVE:  n = VFRONT;
            VFRONT:  n = FEND;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] bar_colour(input logic [9:0] x);
        logic [2:0]  idx;
        logic [15:0] c;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (32'(x) >= 32'(i * BAR_W)) idx = 3'(i);
        end
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] pixel_of(input logic [1:0]  pat,
                                             input logic [15:0] solid,
                                             input logic [9:0]  x,
                                             input logic        y3);
        logic [15:0] p;
        case (pat)
            2'd0:    p = bar_colour(x);
            2'd1:    p = {x[7:3], x[7:2], x[7:3]};
            2'd2:    p = solid;
            default: p = (x[3] ^ y3) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    assign pix = pixel_of(pat_q, solid_q, hcnt_q[10:1], vcnt_q[3]);

    // hcnt/vcnt/state name the byte to be presented at the next pclk fall.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        pclk_d  = pclk_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        db_d    = db_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        latch   = 1'b0;

        if (state_q == IDLE) begin
            pclk_d = 1'b0;
            if (enable) begin
                state_d = VSYNC;
                hcnt_d  = 11'd0;
                vcnt_d  = 10'd0;
                busy_d  = 1'b1;
                pclk_d  = 1'b1;
                latch   = 1'b1;
            end
        end else if (!pclk_q) begin
            pclk_d = 1'b1;
        end else begin
            pclk_d = 1'b0;
            if (state_q == FEND) begin
                done_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                vsync_d = 1'b0;
                href_d  = 1'b0;
                db_d    = 8'h00;
                if (enable) begin
                    state_d = VSYNC;
                    hcnt_d  = 11'd0;
                    vcnt_d  = 10'd0;
                    latch   = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end else begin
                vsync_d = (state_q == VSYNC);
                href_d  = (state_q == ACTIVE) && (hcnt_q < HREF_END);
                db_d    = href_d ? (hcnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
                if (hcnt_q == H_LAST) begin
                    hcnt_d = 11'd0;
                    if (vcnt_q == last_line(state_q)) begin
                        vcnt_d  = 10'd0;
                        state_d = next_state(state_q);
                    end else begin
                        vcnt_d = vcnt_q + 10'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= 11'd0;
            vcnt_q  <= 10'd0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            db_q    <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pclk_q  <= pclk_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame settings are captured once per frame so a mid-frame change cannot tear it.
    always_ff @(posedge clk) begin
        if (latch) begin
            pat_q   <= pattern;
            solid_q <= solid_rgb;
        end
    end

    assign cmos_pclk  = pclk_q;
    assign cmos_vsync = vsync_q;
    assign cmos_href  = href_q;
    assign cmos_db    = db_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule
